assert_scope_arbiter: RTL and testbench

ASSERT_SCOPE_ARBITER -- requirements
Module: assert_scope_arbiter

---
 rtl/assert_scope_arbiter.sv | 119 +++++++++++
 tb/tb_assert_scope_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/assert_scope_arbiter.sv
// rtl/assert_scope_arbiter.sv - round-robin arbiter collecting assertion failures into a record FIFO
// Per-scope enables filter requests; a failure budget drives RUN -> DRAIN -> DONE run termination.
module assert_scope_arbiter #(
  parameter int NSCOPE   = 4,
  parameter int DEPTH    = 4,
  parameter int MAX_FAIL = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSCOPE-1:0]         fail_req,
  output logic [NSCOPE-1:0]         fail_ack,
  input  logic                      cfg_we,
  input  logic [$clog2(NSCOPE)-1:0] cfg_scope,
  input  logic                      cfg_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NSCOPE)-1:0] out_scope,
  output logic [7:0]                out_seq,
  output logic [7:0]                fail_count,
  output logic                      finish_req
);
  localparam int SW = $clog2(NSCOPE);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]  MAX_FAIL_L = 8'(MAX_FAIL);
  localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NSCOPE-1:0] en_q, elig, gnt;
  logic [SW-1:0]     ptr_q, gnt_idx;
  logic              gnt_vld, pop, can_grant;
  logic [7:0]        seq_q, count_q, count_inc;
  logic              finish_q;
  logic [SW+7:0]     mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       occ_q, occ_d;

  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle does not free a slot for this cycle's grant.
  assign can_grant = (state_q == RUN) && (occ_q != DEPTH_L);
  assign elig      = fail_req & en_q & {NSCOPE{can_grant}};

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int j = 0; j < NSCOPE; j++) begin
      int k;
      k = (int'(ptr_q) + j) % NSCOPE;
      if (!gnt_vld && elig[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k[SW-1:0];
        gnt[k]  = 1'b1;
      end
    end
  end

  // Disabled scopes are consumed immediately regardless of FSM state.
  assign fail_ack  = rst ? '0 : ((fail_req & ~en_q) | gnt);
  assign count_inc = (count_q == 8'hff) ? count_q : count_q + 8'd1;

  always_comb begin
    occ_d = occ_q;
    if (gnt_vld && !pop)
      occ_d = occ_q + (AW+1)'(1);
    else if (!gnt_vld && pop)
      occ_d = occ_q - (AW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (gnt_vld && count_inc == MAX_FAIL_L) state_d = DRAIN;
      DRAIN:   if (occ_d == '0) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      en_q     <= '1;
      ptr_q    <= '0;
      seq_q    <= '0;
      count_q  <= '0;
      finish_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (state_d == DONE)
        finish_q <= 1'b1;
      if (cfg_we && int'(cfg_scope) < NSCOPE)
        en_q[cfg_scope] <= cfg_en;
      if (gnt_vld) begin
        wr_q    <= wr_q + AW'(1);
        seq_q   <= seq_q + 8'd1;
        count_q <= count_inc;
        ptr_q   <= (int'(gnt_idx) == NSCOPE - 1) ? '0 : gnt_idx + SW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld)
      mem[wr_q] <= {gnt_idx, seq_q};
  end

  assign out_scope  = mem[rd_q][SW+7:8];
  assign out_seq    = mem[rd_q][7:0];
  assign fail_count = count_q;
  assign finish_req = finish_q;
endmodule

// File: tb/tb_assert_scope_arbiter.sv
// tb/tb_assert_scope_arbiter.sv - scoreboard bench for assert_scope_arbiter
// Two instances (MAX_FAIL 3 and 255) share stimulus; each has its own reference model and record queue.
module tb_assert_scope_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fail_req;
  logic       cfg_we;
  logic [1:0] cfg_scope;
  logic       cfg_en;
  logic       out_ready;

  logic [3:0] ack  [2];
  logic       ov   [2];
  logic [1:0] osc  [2];
  logic [7:0] oseq [2];
  logic [7:0] fcnt [2];
  logic       fin  [2];

  int checks = 0;
  int errors = 0;

  int         max_fail [2] = '{3, 255};
  int         m_state  [2];
  int         m_ptr    [2];
  int         m_seq    [2];
  int         m_cnt    [2];
  int         m_occ    [2];
  logic [3:0] m_en     [2];
  int         g_idx    [2];
  int         q0[$];
  int         q1[$];
  int         ack3_dut0;

  always #5 clk = ~clk;

  assert_scope_arbiter #(.NSCOPE(N), .DEPTH(D), .MAX_FAIL(3)) dut0 (
    .clk(clk), .rst(rst), .fail_req(fail_req), .fail_ack(ack[0]),
    .cfg_we(cfg_we), .cfg_scope(cfg_scope), .cfg_en(cfg_en),
    .out_valid(ov[0]), .out_ready(out_ready), .out_scope(osc[0]), .out_seq(oseq[0]),
    .fail_count(fcnt[0]), .finish_req(fin[0]));

  assert_scope_arbiter #(.NSCOPE(N), .DEPTH(D), .MAX_FAIL(255)) dut1 (
    .clk(clk), .rst(rst), .fail_req(fail_req), .fail_ack(ack[1]),
    .cfg_we(cfg_we), .cfg_scope(cfg_scope), .cfg_en(cfg_en),
    .out_valid(ov[1]), .out_ready(out_ready), .out_scope(osc[1]), .out_seq(oseq[1]),
    .fail_count(fcnt[1]), .finish_req(fin[1]));

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Expected acknowledge set and granted scope (-1 if none) for the current inputs.
  function automatic logic [3:0] model_ack(int k, output int gi);
    logic [3:0] a;
    gi = -1;
    a  = fail_req & ~m_en[k];
    if (m_state[k] == 0 && m_occ[k] < D) begin
      for (int j = 0; j < N; j++) begin
        int i;
        i = (m_ptr[k] + j) % N;
        if (gi < 0 && fail_req[i] && m_en[k][i]) gi = i;
      end
    end
    if (gi >= 0) a[gi] = 1'b1;
    return a;
  endfunction

  task automatic model_update(int k);
    int gi;
    bit pop;
    gi  = g_idx[k];
    pop = (m_occ[k] > 0) && out_ready;
    if (gi >= 0) begin
      if (k == 0) q0.push_back(gi * 256 + m_seq[k]);
      else        q1.push_back(gi * 256 + m_seq[k]);
      m_seq[k] = (m_seq[k] + 1) % 256;
      if (m_cnt[k] < 255) m_cnt[k]++;
      m_ptr[k] = (gi + 1) % N;
      m_occ[k]++;
    end
    if (pop) m_occ[k]--;
    if (m_state[k] == 0 && gi >= 0 && m_cnt[k] == max_fail[k]) m_state[k] = 1;
    else if (m_state[k] == 1 && m_occ[k] == 0) m_state[k] = 2;
    if (cfg_we) m_en[k][cfg_scope] = cfg_en;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ptr[k] = 0; m_seq[k] = 0; m_cnt[k] = 0; m_occ[k] = 0;
      m_en[k] = 4'hf; g_idx[k] = -1;
    end
    q0.delete();
    q1.delete();
  endtask

  // Monitor: compares the presented head record against the scoreboard and pops on handshake.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("d%0d out_valid", k), int'(ov[k]), int'(qsize(k) != 0));
        if (ov[k] && qsize(k) != 0) begin
          check($sformatf("d%0d out_scope", k), int'(osc[k]), qfront(k) / 256);
          check($sformatf("d%0d out_seq", k), int'(oseq[k]), qfront(k) % 256);
          if (out_ready) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
    end
  end

  task automatic step(logic [3:0] req, logic rdy, logic we, logic [1:0] sc, logic en);
    @(negedge clk);
    fail_req = req; out_ready = rdy; cfg_we = we; cfg_scope = sc; cfg_en = en;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ea;
      int gi;
      ea = model_ack(k, gi);
      g_idx[k] = gi;
      check($sformatf("d%0d fail_ack", k), int'(ack[k]), int'(ea));
      check($sformatf("d%0d fail_count", k), int'(fcnt[k]), m_cnt[k]);
      check($sformatf("d%0d finish_req", k), int'(fin[k]), int'(m_state[k] == 2));
    end
    if (ack[0][3]) ack3_dut0++;
    #2;
    for (int k = 0; k < 2; k++) model_update(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    fail_req = 4'hf; cfg_we = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d rst out_valid", k), int'(ov[k]), 0);
      check($sformatf("d%0d rst fail_count", k), int'(fcnt[k]), 0);
      check($sformatf("d%0d rst finish_req", k), int'(fin[k]), 0);
      check($sformatf("d%0d rst fail_ack", k), int'(ack[k]), 0);
    end
    model_reset();
    fail_req = 4'h0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fail_req = '0; cfg_we = 1'b0; cfg_scope = '0; cfg_en = 1'b0; out_ready = 1'b0;
    ack3_dut0 = 0;
    model_reset();
    do_reset();

    // All scopes requesting, consumer always ready: dut0 grants 0,1,2 then terminates.
    for (int c = 0; c < 10; c++) step(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    check("d0 finish after burst", int'(fin[0]), 1);
    check("d0 scope3 acks", ack3_dut0, 0);

    // Disabled scope 2 is dropped without counting.
    do_reset();
    step(4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
    check("d0 count after dropped", int'(fcnt[0]), 0);

    // Back-pressure: FIFO fills at DEPTH, a single pop admits the next record.
    do_reset();
    for (int c = 0; c < 6; c++) step(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);

    // Enable write in the grant cycle takes effect next cycle.
    do_reset();
    step(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    step(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

    // Reset in DRAIN with records queued.
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b0111, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0);

    // Long single-scope run: dut1 saturates at 255 failures and finishes.
    do_reset();
    for (int c = 0; c < 270; c++) step(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    check("d1 count saturated", int'(fcnt[1]), 255);
    check("d1 finish after 255", int'(fin[1]), 1);

    // Randomized traffic with sparse config writes and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) do_reset();
      step(4'($urandom), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
           2'($urandom), ($urandom_range(2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
